// File: rtl/reg_bank_wr_arb.sv
// rtl/reg_bank_wr_arb.sv - round-robin write-port arbiter and clear sequencer for reg_bank
// Optional post-reset clear of all 32 registers is enabled by REG_BANK_WR_ARB_CLEAR_EN.
module reg_bank_wr_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_dr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_dr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [4:0]  dr,
  output logic [31:0] wrdata,
  output logic        write,
  output logic        busy,
  output logic        last_grant
);

  logic running;

`ifdef REG_BANK_WR_ARB_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t     state;
  logic [4:0] cnt;

  assign running = (state == RUN);
  assign busy    = (state == CLEAR);
`else
  assign running = 1'b1;
  assign busy    = 1'b0;
`endif

  // Contention goes to the requester that did not win last; last_grant resets to 1 so req0 wins first.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (running) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) req0_ready = 1'b1;
        else            req1_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write      <= 1'b0;
      dr         <= 5'd0;
      wrdata     <= 32'd0;
      last_grant <= 1'b1;
`ifdef REG_BANK_WR_ARB_CLEAR_EN
      state      <= CLEAR;
      cnt        <= 5'd0;
`endif
    end
`ifdef REG_BANK_WR_ARB_CLEAR_EN
    else if (state == CLEAR) begin
      write  <= 1'b1;
      dr     <= cnt;
      wrdata <= 32'd0;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd31) state <= RUN;
    end
`endif
    else if (req0_valid && req0_ready) begin
      write      <= 1'b1;
      dr         <= req0_dr;
      wrdata     <= req0_data;
      last_grant <= 1'b0;
    end else if (req1_valid && req1_ready) begin
      write      <= 1'b1;
      dr         <= req1_dr;
      wrdata     <= req1_data;
      last_grant <= 1'b1;
    end else begin
      write <= 1'b0;
    end
  end

endmodule
